// File: rtl/eq_band_sched.sv
`default_nettype none
// ============================================================================
// Module   : eq_band_sched
// Purpose  : Walks the enabled equalizer bands once per new sample. It drives
//            the shared tap/coefficient address and the MAC clear and enable
//            strobes, and reports when each band result is valid.
// Revision : 1.0  initial release
// ============================================================================
module eq_band_sched #(
  parameter int NUM_BANDS = 5,
  parameter int TAPS      = 1021,
  parameter int ADDR_W    = 11
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 smpl_rdy,
  input  logic                 q_full,
  input  logic [NUM_BANDS-1:0] band_en,
  output logic                 busy,
  output logic [2:0]           band,
  output logic [ADDR_W-1:0]    tap_addr,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic                 band_vld,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [ADDR_W-1:0] c_LAST_TAP = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_BANDS-1:0] r_en_q;

  logic [2:0] w_first_band;
  logic [2:0] w_next_band;
  logic       w_next_any;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    w_first_band = 3'd0;
    w_next_band  = 3'd0;
    w_next_any   = 1'b0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (band_en[i]) begin
        w_first_band = 3'(i);
      end
      if (r_en_q[i] && (3'(i) > band)) begin
        w_next_band = 3'(i);
        w_next_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state  <= S_IDLE;
      r_en_q   <= '0;
      busy     <= 1'b0;
      band     <= 3'd0;
      tap_addr <= '0;
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      band_vld <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      mac_en   <= (r_state == S_ISSUE);
      mac_clr  <= 1'b0;
      band_vld <= 1'b0;
      done     <= 1'b0;
      if (smpl_rdy && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (smpl_rdy && q_full) begin
            r_en_q <= band_en;
            if (|band_en) begin
              band     <= w_first_band;
              tap_addr <= '0;
              mac_clr  <= 1'b1;
              busy     <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (tap_addr == c_LAST_TAP) begin
            r_state <= S_DRAIN;
          end else begin
            tap_addr <= tap_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          r_state  <= S_VALID;
          band_vld <= 1'b1;
          done     <= !w_next_any;
        end
        S_VALID: begin
          if (w_next_any) begin
            band     <= w_next_band;
            tap_addr <= '0;
            mac_clr  <= 1'b1;
            r_state  <= S_ISSUE;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/eq_band_sched.md
# eq_band_sched

Per-sample scheduler that time-shares one coefficient ROM/MAC datapath across the equalizer's FIR bands. For each new stereo sample written into the sample queues, it walks every enabled band in ascending index order. For each band it issues queue/coefficient addresses, clears and enables the shared accumulator, and flags when that band's result is valid. It sits between the queue write strobe (I2S slave `vld` path) and the FIR accumulator/band-gain stage.

## Interface
- NUM_BANDS, default 5, number of FIR bands sharing the MAC (band indices 0..NUM_BANDS-1)
- TAPS, default 1021, taps per band (queue depth); tap addresses 0..TAPS-1
- ADDR_W, default 11, width of tap_addr; must satisfy 2^ADDR_W >= TAPS
- clk  in  1  system clock
- RST_n  in  1  reset, asynchronous, active-low
- smpl_rdy  in  1  one-cycle pulse: new sample written into the queues
- q_full  in  1  queues hold TAPS valid samples; scheduling is permitted only when this is high
- band_en  in  NUM_BANDS  per-band enable; sampled only when a frame is accepted
- busy  out  1  high in every non-IDLE state
- band  out  3  index of the band currently being addressed/reported
- tap_addr  out  ADDR_W  queue read / coefficient ROM address
- mac_clr  out  1  clear accumulator; coincides with tap_addr==0 issue
- mac_en  out  1  accumulate product; lags the address issue by exactly 1 cycle
- band_vld  out  1  one-cycle pulse: accumulator holds the final result for `band`
- done  out  1  one-cycle pulse: all enabled bands for this sample are complete
- overrun  out  1  sticky; set when smpl_rdy arrives while busy

## Operation
- States: IDLE, ISSUE, DRAIN, VALID.
- IDLE: accepts smpl_rdy only when q_full=1.
  - Latches band_en into en_q.
  - If en_q!=0: band <= lowest set bit, tap_addr <= 0, go ISSUE.
  - If en_q==0: pulse done next cycle, stay IDLE; no band_vld, busy stays 0.
  - smpl_rdy with q_full=0 is ignored and does not set overrun.
- ISSUE: tap_addr increments by 1 each cycle from 0 to TAPS-1.
  - mac_clr=1 only in the tap_addr==0 cycle.
  - At tap_addr==TAPS-1, go DRAIN.
- DRAIN: exactly one cycle; mac_en high for the final tap; tap_addr holds TAPS-1. Go VALID.
- VALID: band_vld=1 for one cycle with `band` still showing the finished band.
  - If en_q has a set bit above `band`: band <= next set bit, tap_addr <= 0, go ISSUE.
  - Otherwise: assert done in this same cycle, then go IDLE.
- mac_en is a 1-cycle registered copy of (state==ISSUE). It is high for exactly TAPS consecutive cycles per band.
- band_en changes while busy have no effect until the next accepted frame.
- smpl_rdy in any non-IDLE state, including the done cycle, sets overrun. That sample is dropped and the current frame continues unchanged.
- overrun clears only on reset.
- tap_addr never exceeds TAPS-1 and does not wrap within a band.
- band never takes a disabled index during ISSUE, DRAIN or VALID.

## Timing
- Cycle 0 is the IDLE cycle in which smpl_rdy is accepted.
- First band: ISSUE occupies cycles 1..TAPS, DRAIN is cycle TAPS+1, VALID is cycle TAPS+2.
- Each band takes TAPS+2 cycles. With N enabled bands, done is asserted at cycle N*(TAPS+2) and the block is in IDLE at N*(TAPS+2)+1.
- Default parameters: 5*1023 = 5115 cycles, which fits inside one I2S sample period.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: busy=0, band=0, tap_addr=0, mac_clr=0, mac_en=0, band_vld=0, done=0, overrun=0, state=IDLE, en_q=0.
- RST_n asserted mid-frame forces these values asynchronously. The next accepted smpl_rdy starts a fresh frame at the lowest enabled band.

## Test plan
- Reset: hold RST_n=0 for 2 cycles, then release -> every output is 0 and state is IDLE; smpl_rdy with q_full=0 -> no activity, overrun stays 0.
- TAPS=8, band_en=5'b11111, one smpl_rdy pulse at cycle 0 with q_full=1 -> expect:
  - bands 0..4 in order, tap_addr 0..7 for each band
  - 5 mac_clr pulses, 40 mac_en cycles
  - band_vld at cycles 10, 20, 30, 40, 50; done at cycle 50; busy low at cycle 51
- TAPS=8, band_en=5'b10100 -> only bands 2 and 4 are addressed; band_vld at cycle 10 (band=2) and cycle 20 (band=4); done at cycle 20; band never shows 0, 1 or 3.
- band_en=0 with smpl_rdy and q_full=1 -> done at cycle 1; busy, band_vld, mac_en and mac_clr stay 0.
- TAPS=8, band_en=5'b00011, second smpl_rdy at cycle 5 -> overrun=1 from cycle 6 and stays set; done still at cycle 20; no extra frame runs.
- TAPS=8, all bands enabled, RST_n pulsed low at cycle 15 -> all outputs 0 immediately, overrun cleared; the next smpl_rdy starts at band 0 with tap_addr 0.
